top_udiv_19ns_9ns_12_seq: RTL and testbench

TOP_UDIV_19NS_9NS_12_SEQ -- requirements
Module: top_udiv_19ns_9ns_12_seq

---
 rtl/top_udiv_19ns_9ns_12_seq.sv | 95 +++++++++
 tb/tb_top_udiv_19ns_9ns_12_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/top_udiv_19ns_9ns_12_seq.sv
// rtl/top_udiv_19ns_9ns_12_seq.sv - sequential restoring divider, 19-bit / 9-bit, 12-bit quotient
// One quotient bit per clock-enabled edge, MSB first; results held until the next one is written.
module top_udiv_19ns_9ns_12_seq #(
  parameter ID         = 32'd1,
  parameter din0_WIDTH = 32'd19,
  parameter din1_WIDTH = 32'd9,
  parameter dout_WIDTH = 32'd12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ready,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [4:0] LAST_STEP = 5'(din0_WIDTH - 1);

  logic [1:0]            state;
  logic [4:0]            cnt;
  logic [din0_WIDTH-1:0] work;     // dividend bits shift out of the top, quotient bits in at the bottom
  logic [din1_WIDTH-1:0] acc;
  logic [din1_WIDTH-1:0] divisor;

  logic [din1_WIDTH:0]   partial;
  logic [din1_WIDTH:0]   diff;
  logic                  take;
  logic [din1_WIDTH-1:0] next_acc;
  logic [din0_WIDTH-1:0] next_work;

  always_comb begin
    partial   = {acc, work[din0_WIDTH-1]};
    diff      = partial - {1'b0, divisor};
    take      = (partial >= {1'b0, divisor});
    next_acc  = take ? diff[din1_WIDTH-1:0] : partial[din1_WIDTH-1:0];
    next_work = {work[din0_WIDTH-2:0], take};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      work    <= '0;
      acc     <= '0;
      divisor <= '0;
      dout    <= '0;
      rem     <= '0;
      ovf     <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE, DONE: begin
          if (start && (din1 != '0)) begin
            divisor <= din1;
            work    <= din0;
            acc     <= '0;
            cnt     <= LAST_STEP;
            state   <= BUSY;
          end else if (start) begin
            dout  <= '1;
            rem   <= '0;
            ovf   <= 1'b1;
            state <= DONE;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          work <= next_work;
          acc  <= next_acc;
          cnt  <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            dout  <= next_work[dout_WIDTH-1:0];
            rem   <= next_acc;
            ovf   <= |next_work[din0_WIDTH-1:dout_WIDTH];
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready = (state != BUSY);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_top_udiv_19ns_9ns_12_seq.sv
// tb/tb_top_udiv_19ns_9ns_12_seq.sv - scoreboard bench for the sequential divider
// Stimulus queues hand-computed results with their done edge; a negedge monitor checks each done.
module tb_top_udiv_19ns_9ns_12_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        start = 1'b0;
  logic [18:0] din0 = '0;
  logic [8:0]  din1 = '0;
  logic        ready;
  logic        done;
  logic [11:0] dout;
  logic [8:0]  rem;
  logic        ovf;

  top_udiv_19ns_9ns_12_seq #(
    .ID(32'd1), .din0_WIDTH(32'd19), .din1_WIDTH(32'd9), .dout_WIDTH(32'd12)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start), .din0(din0), .din1(din1),
    .ready(ready), .done(done), .dout(dout), .rem(rem), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] q;
    logic [8:0]  r;
    logic        o;
    int          edge_n;
  } exp_t;

  typedef struct {
    logic [18:0] a;
    logic [8:0]  b;
    logic [11:0] q;
    logic [8:0]  r;
    logic        o;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  logic last_ce = 1'b0;

  vec_t vecs[9] = '{
    '{19'd100000, 9'd250, 12'd400,  9'd0,   1'b0},
    '{19'd1000,   9'd7,   12'd142,  9'd6,   1'b0},
    '{19'd524287, 9'd1,   12'hFFF,  9'd0,   1'b1},
    '{19'd5,      9'd0,   12'hFFF,  9'd0,   1'b1},
    '{19'd524287, 9'd511, 12'd1026, 9'd1,   1'b0},
    '{19'd8192,   9'd2,   12'd0,    9'd0,   1'b1},
    '{19'd6,      9'd7,   12'd0,    9'd6,   1'b0},
    '{19'd511,    9'd511, 12'd1,    9'd0,   1'b0},
    '{19'd409500, 9'd100, 12'd4095, 9'd0,   1'b0}
  };

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    last_ce  <= ce & ~reset;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  // A done entered on a clock-enabled edge is a new result; ce-stalled DONE cycles are not.
  always @(negedge clk) begin
    if (done === 1'b1 && last_ce === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("dout", 32'(dout), 32'(e.q));
        check("rem", 32'(rem), 32'(e.r));
        check("ovf", 32'(ovf), 32'(e.o));
        check("done_edge", 32'(edge_cnt), 32'(e.edge_n));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [18:0] a, input logic [8:0] b, input logic [11:0] q,
                       input logic [8:0] r, input logic o, input int extra, input bit push);
    din0  = a;
    din1  = b;
    start = 1'b1;
    if (push) exp_q.push_back('{q, r, o, edge_cnt + ((b == 9'd0) ? 1 : 20) + extra});
    tick();
    start = 1'b0;
    if (b != 9'd0) check("busy_not_ready", 32'(ready), 32'd0);
    else           check("zdiv_done", 32'(done), 32'd1);
  endtask

  task automatic wait_done;
    int n = 0;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    if (done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    tick(); tick(); tick();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_rem", 32'(rem), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    ce = 1'b1;
    tick();

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].o, 0, 1'b1);
      wait_done();
      tick();
    end

    // ce stall mid-operation, then stall inside DONE
    issue(19'd1000, 9'd7, 12'd142, 9'd6, 1'b0, 5, 1'b1);
    tick(); tick(); tick();
    ce = 1'b0;
    repeat (5) tick();
    ce = 1'b1;
    wait_done();
    ce = 1'b0;
    tick(); tick(); tick();
    check("stall_done_held", 32'(done), 32'd1);
    check("stall_ready", 32'(ready), 32'd1);
    ce = 1'b1;
    tick();
    check("idle_done_low", 32'(done), 32'd0);
    check("idle_dout_kept", 32'(dout), 32'd142);

    // start and operand changes during BUSY are ignored
    issue(19'd12345, 9'd123, 12'd100, 9'd45, 1'b0, 0, 1'b1);
    check("busy_dout_kept", 32'(dout), 32'd142);
    tick(); tick();
    din0 = 19'd1; din1 = 9'd1; start = 1'b1;
    tick();
    start = 1'b0;
    din1 = 9'd0;
    wait_done();
    tick();

    // reset aborts an operation; new start accepted on first edge after reset
    issue(19'd100000, 9'd250, 12'd0, 9'd0, 1'b0, 0, 1'b0);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    check("abort_dout", 32'(dout), 32'd0);
    check("abort_rem", 32'(rem), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    reset = 1'b0;
    issue(19'd1000, 9'd7, 12'd142, 9'd6, 1'b0, 0, 1'b1);
    wait_done();
    tick();

    // back-to-back: start held with new operands during DONE
    issue(19'd100000, 9'd250, 12'd400, 9'd0, 1'b0, 0, 1'b1);
    wait_done();
    din0 = 19'd6; din1 = 9'd7; start = 1'b1;
    exp_q.push_back('{12'd0, 9'd6, 1'b0, edge_cnt + 20});
    tick();
    start = 1'b0;
    check("b2b_busy", 32'(ready), 32'd0);
    wait_done();
    tick();

    repeat (25) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
